// File: rtl/alu_md.sv
// ALU with an iterative multiply/divide unit: basic ops complete in one cycle,
// M-extension ops run a WIDTH-step shift-add / restoring-divide sequence.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALU_operation,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             Zero,
  output logic [1:0]       state_o
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready.
  state_t state_q, state_d;
  logic              accept, is_mop, idle;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [2:0]        sub_q, sub_d;
  logic              neg_q, neg_d, aneg_q, aneg_d, div0_q, div0_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              zero_q, zero_d;

  logic [SW-1:0]     shamt;
  logic [WIDTH-1:0]  basic_res;
  logic              sign_a, sign_b, a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              s_div;
  logic [WIDTH-1:0]  s_m;
  logic [2*WIDTH-1:0] s_p, p_step, prod;
  logic [WIDTH:0]    msum, shifted, diff;
  logic              ge;
  logic [WIDTH-1:0]  quo, rmd, m_res;

  assign accept = in_valid && in_ready;
  assign is_mop = (ALU_operation[4:3] == 2'b10);
  assign idle   = (state_q == IDLE);
  assign shamt  = op2[SW-1:0];

  always_comb begin
    basic_res = '0;
    case (ALU_operation)
      5'b00000: basic_res = op1 + op2;
      5'b00001: basic_res = op1 - op2;
      5'b00010: basic_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      5'b00011: basic_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      5'b00100: basic_res = op1 & op2;
      5'b00101: basic_res = op1 | op2;
      5'b00110: basic_res = op1 ^ op2;
      5'b00111: basic_res = op1 << shamt;
      5'b01000: basic_res = op1 >> shamt;
      5'b01001: basic_res = $signed(op1) >>> shamt;
      default:  basic_res = '0;
    endcase
  end

  // Operand signedness: bit 2 selects the divide group, low bits pick the variant.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    if (ALU_operation[2]) begin
      sign_a = ~ALU_operation[0];
      sign_b = ~ALU_operation[0];
    end else begin
      sign_a = ALU_operation[1] ^ ALU_operation[0];
      sign_b = (ALU_operation[1:0] == 2'b01);
    end
  end

  assign a_neg = sign_a & op1[WIDTH-1];
  assign b_neg = sign_b & op2[WIDTH-1];
  assign a_mag = a_neg ? -op1 : op1;
  assign b_mag = b_neg ? -op2 : op2;

  // The accept edge performs the first step straight from the operands, so
  // WIDTH steps complete by the WIDTH-th edge counting the accept edge.
  assign s_div = idle ? ALU_operation[2] : sub_q[2];
  assign s_m   = idle ? (ALU_operation[2] ? b_mag : a_mag) : m_q;
  assign s_p   = idle ? {{WIDTH{1'b0}}, (ALU_operation[2] ? a_mag : b_mag)} : p_q;

  assign msum    = {1'b0, s_p[2*WIDTH-1:WIDTH]} + (s_p[0] ? {1'b0, s_m} : {(WIDTH+1){1'b0}});
  assign shifted = {s_p[2*WIDTH-1:WIDTH], s_p[WIDTH-1]};
  assign diff    = shifted - {1'b0, s_m};
  assign ge      = ~diff[WIDTH];
  assign p_step  = s_div ? {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), s_p[WIDTH-2:0], ge}
                         : {msum, s_p[WIDTH-1:1]};

  assign prod = neg_q ? -p_step : p_step;
  assign quo  = p_step[WIDTH-1:0];
  assign rmd  = p_step[2*WIDTH-1:WIDTH];

  // Divide-by-zero leaves quotient all ones and remainder = |op1|; only the
  // signed quotient must skip sign correction to stay all ones.
  always_comb begin
    m_res = '0;
    case (sub_q)
      3'b000:                m_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: m_res = prod[2*WIDTH-1:WIDTH];
      3'b100:                m_res = div0_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
      3'b101:                m_res = quo;
      3'b110:                m_res = aneg_q ? -rmd : rmd;
      default:               m_res = rmd;
    endcase
  end

  always_comb begin
    p_d    = p_q;
    m_d    = m_q;
    sub_d  = sub_q;
    neg_d  = neg_q;
    aneg_d = aneg_q;
    div0_d = div0_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mop) begin
            p_d    = p_step;
            m_d    = s_m;
            sub_d  = ALU_operation[2:0];
            neg_d  = a_neg ^ b_neg;
            aneg_d = a_neg;
            div0_d = (op2 == '0);
            cnt_d  = SW'(1);
          end else begin
            res_d  = basic_res;
            zero_d = (basic_res == '0);
          end
        end
      end
      CALC: begin
        p_d   = p_step;
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == LAST) begin
          res_d  = m_res;
          zero_d = (m_res == '0);
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      sub_q   <= '0;
      neg_q   <= 1'b0;
      aneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      sub_q   <= sub_d;
      neg_q   <= neg_d;
      aneg_q  <= aneg_d;
      div0_q  <= div0_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_mop ? CALC : DONE;
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    state_o   = state_q;
  end

  assign ALU_result = res_q;
  assign Zero       = zero_q;

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md (WIDTH = 32): directed corner cases, backpressure, reset
// abort and random traffic checked by a queue-based scoreboard.
module tb_alu_md;

  localparam int W = 32;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   ALU_operation;
  logic [W-1:0] op1, op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_result;
  logic         Zero;
  logic [1:0]   state_o;

  alu_md #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_operation(ALU_operation), .op1(op1), .op2(op2),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_result(ALU_result), .Zero(Zero), .state_o(state_o)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];
  int         lat_q[$];
  int         acc_q[$];

  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = 1'b0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural reference model
  function automatic logic [W-1:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    logic [W-1:0] ones, min_neg;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ones = 32'hFFFF_FFFF;
    min_neg = 32'h8000_0000;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return {31'b0, ($signed(a) < $signed(b))};
      5'd3:  return {31'b0, (a < b)};
      5'd4:  return a & b;
      5'd5:  return a | b;
      5'd6:  return a ^ b;
      5'd7:  return a << b[4:0];
      5'd8:  return a >> b[4:0];
      5'd9:  return $signed(a) >>> b[4:0];
      5'd16: begin p = ua * ub; return p[31:0]; end
      5'd17: begin p = sa * sb; return p[63:32]; end
      5'd18: begin p = sa * ub; return p[63:32]; end
      5'd19: begin p = ua * ub; return p[63:32]; end
      5'd20: begin
        if (b == 0) return ones;
        if (a == min_neg && b == ones) return a;
        p = sa / sb;
        return p[31:0];
      end
      5'd21: return (b == 0) ? ones : a / b;
      5'd22: begin
        if (b == 0) return a;
        if (a == min_neg && b == ones) return '0;
        p = sa % sb;
        return p[31:0];
      end
      5'd23: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // driver tasks (called at posedge + 1)
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res);
    int n;
    logic r;
    n = 0;
    ALU_operation = op;
    op1 = a;
    op2 = b;
    in_valid = 1'b1;
    do begin
      @(negedge clock);
      r = in_ready;
      @(posedge clock);
      n++;
    end while (!r && n < 300);
    #1;
    in_valid = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    ALU_operation = 5'($urandom_range(0, 31));
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready low for %0d cycles expected accept", n);
    end else begin
      exp_q.push_back({(res == '0), res});
      lat_q.push_back((op[4:3] == 2'b10) ? W : 1);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // scoreboard monitor
  logic       prev_v = 1'b0;
  logic       cons = 1'b0;
  logic [W:0] held;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_v = 1'b0;
      cons = 1'b0;
    end else begin
      if (cons) begin
        chk("idle_after_consume", 64'({out_valid, in_ready}), 64'(2'b01));
        cons = 1'b0;
      end
      if (out_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_result: got %h expected none", ALU_result);
          end else begin
            logic [W:0] e;
            int l, a;
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            a = acc_q.pop_front();
            chk("result", 64'({Zero, ALU_result}), 64'(e));
            chk("latency", 64'(cyc - a + 1), 64'(l));
            chk("in_ready_busy", 64'(in_ready), 64'(0));
          end
          held = {Zero, ALU_result};
        end else begin
          chk("hold_stable", 64'({Zero, ALU_result}), 64'(held));
        end
        if (out_ready) cons = 1'b1;
      end
      prev_v = out_valid;
    end
  end

  logic [4:0] op_tab [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                              5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                              5'd10, 5'd27};

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    ALU_operation = '0;
    op1 = '0;
    op2 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_result", 64'({Zero, ALU_result}), 64'(0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", 64'(in_ready), 64'(1));
    @(posedge clock);
    #1;

    // directed corner cases
    send(5'd0,  32'd12, -32'd12, 32'd0);
    send(5'd2,  -32'd88, 32'd120, 32'd1);
    send(5'd3,  -32'd344, 32'd789, 32'd0);
    send(5'd9,  32'h8000_0000, 32'd33, 32'hC000_0000);
    send(5'd16, -32'd7, 32'd6, 32'hFFFF_FFD6);
    send(5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    send(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    send(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(5'd20, -32'd45, 32'd22, 32'hFFFF_FFFE);
    send(5'd22, -32'd45, 32'd22, 32'hFFFF_FFFF);
    send(5'd21, 32'd17, 32'd0, 32'hFFFF_FFFF);
    send(5'd23, 32'd17, 32'd0, 32'd17);
    send(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    send(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    send(5'd20, -32'd5, 32'd0, 32'hFFFF_FFFF);
    send(5'd22, -32'd5, 32'd0, -32'd5);
    send(5'd31, 32'd3, 32'd4, 32'd0);
    drain();

    // backpressure: result held, no accept while DONE even with out_ready
    ready_mode = 2;
    send(5'd0, 32'd5, 32'd7, 32'd12);
    in_valid = 1'b1;
    ALU_operation = 5'd0;
    op1 = 32'd1;
    op2 = 32'd1;
    repeat (5) begin
      @(negedge clock);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
    end
    ready_mode = 0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // random traffic
    ready_mode = 1;
    for (int i = 0; i < 120; i++) begin
      logic [4:0] op;
      logic [W-1:0] a, b;
      int gap;
      op = op_tab[$urandom_range(0, 19)];
      a = rand_opnd();
      b = rand_opnd();
      send(op, a, b, ref_alu(op, a, b));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clock);
        #1;
      end
    end
    drain();

    // reset in the middle of a multiply aborts it
    ready_mode = 0;
    send(5'd0, 32'd3, 32'd4, 32'd7);
    drain();
    send(5'd16, 32'd1234, 32'd5678, 32'd0);
    while (cyc - acc_q[$] < 9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    @(posedge clock);
    @(negedge clock);
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_result", 64'({Zero, ALU_result}), 64'(0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_ready", 64'(in_ready), 64'(1));
    repeat (40) @(posedge clock);
    #1;
    send(5'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
